uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Front end of the instruction-fetch stage. Receives a program over the board UART RX pin and assembles 16-bit instructions from byte pairs.
- Writes each instruction into instruction memory one word at a time.
- Raises load_done when the program is complete; PC control holds the PC at 0 until then.
- Sits directly upstream of instruction memory and PC control, and drives the LED16_B status.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4).
- ADDR_W, 8, instruction address width; maximum program is 2**ADDR_W words.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- UART_TXD_IN  in  1  asynchronous serial input; idles high; 8N1 format, LSB first.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  16  instruction word {hi_byte, lo_byte}.
- load_done  out  1  high once the last word is written; held until RST.
- frame_err  out  1  sticky; set on any bad stop bit.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, frame_err=0. Both FSMs go to their idle state, and all counters are cleared.
- A reset mid-frame or mid-program abandons the transfer. Words already written in memory are not erased.
- Input synchronization: UART_TXD_IN passes through a 2-flop synchronizer, so the receiver sees it 2 cycles late.
- RX FSM states:
  - RX_IDLE: on a sampled 0, go to RX_START and load the bit timer with CLKS_PER_BIT/2.
  - RX_START: when the timer expires, sample the line.
    - Line still 0: go to RX_DATA.
    - Line is 1: treat as a glitch and return to RX_IDLE with no output.
  - RX_DATA: sample at each CLKS_PER_BIT interval, eight samples, shifting LSB first.
  - RX_STOP: sample once more after CLKS_PER_BIT.
    - Sample is 1: pulse byte_valid for 1 cycle with the byte.
    - Sample is 0: set frame_err, discard the byte, and go to RX_IDLE. RX_IDLE then waits for the line to return high before accepting a new start bit.
- Loader protocol:
  - Byte 0 is the word count N. N=0 means 2**ADDR_W words.
  - This is followed by N byte pairs, high byte first.
- Loader FSM states:
  - L_COUNT: on byte_valid, latch N and go to L_HI.
  - L_HI: on byte_valid, latch the high byte and go to L_LO.
  - L_LO: on byte_valid, register imem_wdata={hi,byte} and imem_addr=idx, and assert imem_we in the next cycle for exactly 1 cycle. Then increment idx.
    - If idx was N-1 (modulo 2**ADDR_W): go to L_DONE and set load_done in the same cycle as imem_we.
    - Otherwise: go to L_HI.
  - L_DONE: all further bytes are ignored. imem_we stays 0 and load_done stays 1.
- Latency: the imem_we edge follows the byte_valid of the low byte by 1 cycle.
- A framing error does not reset loader state. The dropped byte simply never arrives, so the host must reset to retry.
- idx wraps naturally at 2**ADDR_W; no out-of-range write is possible.
- imem_addr and imem_wdata hold their last written values between strobes.

Decomposition:
- Shared package loader_pkg holds:
  - the RX state enum (RX_IDLE, RX_START, RX_DATA, RX_STOP);
  - the loader state enum (L_COUNT, L_HI, L_LO, L_DONE);
  - the CLKS_PER_BIT derivation function.
- One sub-module, uart_rx_byte (synchronizer plus RX FSM), outputs rx_byte[7:0], byte_valid and frame_err_pulse.
- The loader FSM lives in the top module.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10):
- Reset then send bytes 02,12,34,AB,CD -> two imem_we pulses: addr 0 / data 1234, then addr 1 / data ABCD. load_done rises with the second pulse.
- After the case above, send extra bytes 55,66 -> no imem_we, and load_done stays 1.
- Send 01,12 followed by a frame of 0x34 whose stop bit is 0 -> frame_err=1, no write, and the loader waits in L_LO. Then send a good 0x34 -> write addr 0 / data 1234 and load_done=1.
- 3-cycle low glitch on an idle line -> no byte_valid, no state change, frame_err=0.
- Assert RST after 03,AA,BB,CC -> all outputs return to 0. Then send 01,DE,AD -> write addr 0 / data DEAD and load_done=1.
- Send count 00 followed by 256 byte pairs -> 256 writes at addr 0..255 in order. load_done rises on the addr-255 write, and no write occurs after it.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   rx_state_t    - UART receive FSM states
//   ld_state_t    - program-loader FSM states
//   clks_per_bit  - system clocks per UART bit (integer division)
package loader_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      L_COUNT,
      L_HI,
      L_LO,
      L_DONE
   } ld_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Latency: byte_valid pulses 1 cycle after the mid-stop-bit sample.
// Backpressure: none; the consumer must take each byte on its valid pulse.
//
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_rxd               - asynchronous serial line, idles high
//   o_rx_byte           - last received byte (stable while o_byte_valid is high)
//   o_byte_valid        - 1-cycle strobe for a byte with a good stop bit
//   o_frame_err_pulse   - 1-cycle strobe when a stop bit is sampled low
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic [7:0] o_rx_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err_pulse
);

   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
   localparam int TW  = $clog2(CPB);
   localparam logic [TW-1:0] HALF_BIT = TW'(CPB / 2);
   localparam logic [TW-1:0] FULL_M1  = TW'(CPB - 1);

   logic            r_sync1;
   logic            r_sync2;
   rx_state_t       r_state;
   rx_state_t       w_next;
   logic [TW-1:0]   r_timer;
   logic [2:0]      r_bitcnt;
   logic [7:0]      r_shift;
   logic            r_armed;
   logic            r_byte_valid;
   logic            r_frame_err;
   logic            w_line;
   logic            w_tick;

   assign w_line = r_sync2;
   assign w_tick = (r_timer == '0);

   assign o_rx_byte         = r_shift;
   assign o_byte_valid      = r_byte_valid;
   assign o_frame_err_pulse = r_frame_err;

   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_IDLE:  if (r_armed && !w_line) w_next = RX_START;
         RX_START: if (w_tick) w_next = w_line ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick && (r_bitcnt == 3'd7)) w_next = RX_STOP;
         RX_STOP:  if (w_tick) w_next = RX_IDLE;
         default:  w_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_state      <= RX_IDLE;
         r_timer      <= '0;
         r_bitcnt     <= '0;
         r_shift      <= '0;
         r_armed      <= 1'b0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_sync1      <= i_rxd;
         r_sync2      <= r_sync1;
         r_state      <= w_next;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               // A new start bit is only accepted once the line has been
               // seen high, so a line stuck low after a bad stop bit (or
               // a reset mid-frame) cannot fake a start.
               if (w_line) r_armed <= 1'b1;
               if (r_armed && !w_line) r_timer <= HALF_BIT;
            end
            RX_START: begin
               if (w_tick) begin
                  r_timer  <= FULL_M1;
                  r_bitcnt <= '0;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            RX_DATA: begin
               if (w_tick) begin
                  r_shift  <= {w_line, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  r_timer  <= FULL_M1;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            RX_STOP: begin
               if (w_tick) begin
                  if (w_line) begin
                     r_byte_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_armed     <= 1'b0;
                  end
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: r_timer <= '0;
         endcase
      end
   end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program from the UART into instruction memory, one 16-bit word per byte pair.
// Latency: imem_we rises 1 cycle after the low byte's byte_valid.
// Backpressure: none; instruction memory must accept every write strobe.
//
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   UART_TXD_IN  - serial input, 8N1, LSB first; byte 0 = word count N (0 -> 2**ADDR_W)
//   imem_we      - 1-cycle write strobe
//   imem_addr    - write word address (holds between strobes)
//   imem_wdata   - {hi, lo} instruction word (holds between strobes)
//   load_done    - set with the final write, held until reset
//   frame_err    - sticky, set on any bad stop bit
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600,
   parameter int ADDR_W   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              UART_TXD_IN,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              load_done,
   output logic              frame_err
);

   logic [7:0]        w_rx_byte;
   logic              w_byte_valid;
   logic              w_frame_err_pulse;

   ld_state_t         r_state;
   ld_state_t         w_next;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] r_idx;
   logic [7:0]        r_hi;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic              r_done;
   logic              r_ferr;
   logic              w_last;

   uart_rx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .i_clk             (CLK),
      .i_rst             (RST),
      .i_rxd             (UART_TXD_IN),
      .o_rx_byte         (w_rx_byte),
      .o_byte_valid      (w_byte_valid),
      .o_frame_err_pulse (w_frame_err_pulse)
   );

   // Count N=0 wraps to all-ones here, which yields 2**ADDR_W words.
   assign w_last = (r_idx == (r_count - ADDR_W'(1)));

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign load_done  = r_done;
   assign frame_err  = r_ferr;

   always_comb begin
      w_next = r_state;
      case (r_state)
         L_COUNT: if (w_byte_valid) w_next = L_HI;
         L_HI:    if (w_byte_valid) w_next = L_LO;
         L_LO:    if (w_byte_valid) w_next = w_last ? L_DONE : L_HI;
         L_DONE:  w_next = L_DONE;
         default: w_next = L_COUNT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= L_COUNT;
         r_count <= '0;
         r_idx   <= '0;
         r_hi    <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_we    <= 1'b0;
         if (w_frame_err_pulse) r_ferr <= 1'b1;
         if (w_byte_valid) begin
            case (r_state)
               L_COUNT: r_count <= ADDR_W'(w_rx_byte);
               L_HI:    r_hi    <= w_rx_byte;
               L_LO: begin
                  r_we    <= 1'b1;
                  r_addr  <= r_idx;
                  r_wdata <= {r_hi, w_rx_byte};
                  r_idx   <= r_idx + ADDR_W'(1);
                  if (w_last) r_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

   localparam int CPB = 10;

   logic        CLK = 1'b0;
   logic        RST;
   logic        UART_TXD_IN;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        load_done;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   // Reference state: bytes delivered with a good stop bit since the last reset.
   logic [7:0]  rx_q[$];
   // Observed writes.
   logic [7:0]  wr_addr[$];
   logic [15:0] wr_data[$];
   logic        wr_done[$];

   uart_program_loader #(
      .CLK_FREQ (1000000),
      .BAUD     (100000),
      .ADDR_W   (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .UART_TXD_IN (UART_TXD_IN),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .load_done   (load_done),
      .frame_err   (frame_err)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         wr_done.push_back(load_done);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      UART_TXD_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      UART_TXD_IN = 1'b1;
      rx_q.delete();
      wr_addr.delete();
      wr_data.delete();
      wr_done.delete();
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic good_stop);
      logic [9:0] frame;
      frame = {good_stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         UART_TXD_IN = frame[i];
         repeat (CPB) @(negedge CLK);
      end
      UART_TXD_IN = 1'b1;
      repeat (2) @(negedge CLK);
      if (good_stop) rx_q.push_back(b);
   endtask

   task automatic check_zero_outputs();
      check("rst_we",    imem_we,    0);
      check("rst_addr",  imem_addr,  0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_done",  load_done,  0);
      check("rst_ferr",  frame_err,  0);
   endtask

   // Expected results derived from the byte stream: N words from N byte
   // pairs following the count byte; surplus bytes are ignored.
   task automatic check_program(input logic exp_ferr);
      int n;
      int pairs;
      int nw;
      logic [15:0] exp_word;
      pairs = (rx_q.size() > 0) ? (rx_q.size() - 1) / 2 : 0;
      n     = (rx_q.size() == 0) ? 1 : ((rx_q[0] == 8'd0) ? 256 : int'(rx_q[0]));
      nw    = (pairs < n) ? pairs : n;
      check("write_count", wr_addr.size(), nw);
      for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
         exp_word = {rx_q[1 + 2 * i], rx_q[2 + 2 * i]};
         check("write_addr", wr_addr[i], i[7:0]);
         check("write_data", wr_data[i], exp_word);
         check("done_at_write", wr_done[i], (i == n - 1));
      end
      check("load_done", load_done, (rx_q.size() > 0 && pairs >= n));
      check("frame_err", frame_err, exp_ferr);
   endtask

   initial begin
      logic [7:0] r;
      RST = 1'b1;
      UART_TXD_IN = 1'b1;

      // Reset values
      do_reset();
      check_zero_outputs();

      // Two-word program, then surplus bytes ignored
      send_byte(8'h02, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      idle(30);
      check_program(1'b0);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      idle(30);
      check_program(1'b0);

      // Framing error drops one byte; loader keeps waiting for it
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b0);
      idle(30);
      check_program(1'b1);
      send_byte(8'h34, 1'b1);
      idle(30);
      check_program(1'b1);

      // Short low glitch on an idle line is rejected
      do_reset();
      idle(5);
      UART_TXD_IN = 1'b0;
      repeat (3) @(negedge CLK);
      idle(40);
      check_program(1'b0);
      send_byte(8'h01, 1'b1);
      send_byte(8'($urandom_range(255)), 1'b1);
      send_byte(8'($urandom_range(255)), 1'b1);
      idle(30);
      check_program(1'b0);

      // Reset mid-program abandons it; a fresh load then works
      do_reset();
      send_byte(8'h03, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      idle(20);
      check_program(1'b0);
      do_reset();
      check_zero_outputs();
      send_byte(8'h01, 1'b1);
      send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b1);
      idle(30);
      check_program(1'b0);

      // Count 0 means a full 256-word program; address wraps cleanly
      do_reset();
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 512; i++) begin
         r = 8'($urandom_range(255));
         send_byte(r, 1'b1);
      end
      idle(30);
      check_program(1'b0);
      send_byte(8'($urandom_range(255)), 1'b1);
      send_byte(8'($urandom_range(255)), 1'b1);
      idle(30);
      check_program(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
